bcd_operand_loader: RTL and testbench



---
 rtl/bcd_operand_loader_if.sv | 47 ++++
 rtl/bcd_operand_loader.sv | 180 ++++++++++++++++++
 tb/tb_bcd_operand_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_operand_loader_if.sv
//------------------------------------------------------------------------------
// bcd_operand_loader_if
//
// Purpose: bundles the operand-entry bus of bcd_operand_loader. The clock and
// reset stay outside this interface.
//
// Signals:
//   D      [3:0]  digit entry bus (switches)
//   Cin           carry-in entry (switch), sampled together with the Y digit
//   Load          load button, active-high, asynchronous to the clock
//   X      [3:0]  captured first operand
//   Y      [3:0]  captured second operand
//   ci            captured carry-in
//   Valid         X/Y/ci form a complete validated operand set
//   Err           sticky: the last load attempt carried a non-BCD digit
//   State  [1:0]  loader FSM state (00 WAIT_X, 01 WAIT_Y, 10 READY)
//
// Handshake: there is no valid/ready pair here. Each low-to-high transition of
// Load is one load request, and it is always accepted. The consumer samples
// X/Y/ci only while Valid is high. Those outputs change only on a clock edge
// that also updates State.
//
// Modports:
//   master - the entry side (drives D/Cin/Load, observes the results)
//   slave  - the loader itself
//------------------------------------------------------------------------------
interface bcd_operand_loader_if;
   logic [3:0] D;
   logic       Cin;
   logic       Load;
   logic [3:0] X;
   logic [3:0] Y;
   logic       ci;
   logic       Valid;
   logic       Err;
   logic [1:0] State;

   modport master (
      output D, Cin, Load,
      input  X, Y, ci, Valid, Err, State
   );

   modport slave (
      input  D, Cin, Load,
      output X, Y, ci, Valid, Err, State
   );
endinterface

// File: rtl/bcd_operand_loader.sv
//------------------------------------------------------------------------------
// bcd_operand_loader
//
// Purpose: operand-entry stage for the single-digit BCD adder. It captures two
// BCD digits (X, then Y together with ci) from a shared switch bus, one digit
// per press of the Load button. Non-BCD codes (10..15) are rejected and flagged
// on Err. The adder only sees X/Y/ci as a legal set while Valid is high.
//
// Ports:
//   Clock   system clock; every state update happens on the rising edge
//   Resetn  synchronous, active-low reset (it has priority over a load event)
//   bus     bcd_operand_loader_if.slave:
//             D, Cin, Load in
//             X, Y, ci, Valid, Err, State out
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples required before the filtered Load changes
//   CNT_W            debounce counter width; 2**CNT_W must exceed DEBOUNCE_CYCLES
//
// Build option:
//   BCD_OPERAND_LOADER_DEBOUNCE_EN
//     When defined, a debounce filter sits between the synchronizer and the
//     edge detector, and the capture latency becomes 3 + DEBOUNCE_CYCLES.
//     When undefined, there is no filter and the capture latency is 3 cycles.
//
// Timing (default build): if Load rises before edge k, the data is captured at
// edge k+2. D and Cin are sampled directly at that capture edge. They are
// quasi-static switches, so they are not synchronized.
//------------------------------------------------------------------------------
module bcd_operand_loader #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   bcd_operand_loader_if.slave  bus
);

   // 2'b11 has no entry path. It is listed only so that it can be recovered
   // from explicitly.
   typedef enum logic [1:0] {
      WAIT_X = 2'b00,
      WAIT_Y = 2'b01,
      READY  = 2'b10,
      BAD    = 2'b11
   } state_t;

   state_t     state_q, state_n;
   logic [3:0] x_q, x_n;
   logic [3:0] y_q, y_n;
   logic       ci_q, ci_n;
   logic       err_q, err_n;

   // Load synchronizer, and the previous-level flop used by the edge detector
   logic s1, s2, p;
   logic lvl;      // Load level as seen by the edge detector
   logic ld_evt;   // one-cycle load event
   logic digit_ok;

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         p  <= 1'b0;
      end else begin
         s1 <= bus.Load;
         s2 <= s1;
         p  <= lvl;
      end
   end

`ifdef BCD_OPERAND_LOADER_DEBOUNCE_EN
   // The filtered level follows s2 only after s2 has disagreed with it for
   // DEBOUNCE_CYCLES consecutive cycles. The counter restarts whenever the two
   // agree again, so a shorter glitch is dropped.
   logic [CNT_W-1:0] db_cnt;
   logic             db_lvl;

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         db_cnt <= '0;
         db_lvl <= 1'b0;
      end else if (s2 == db_lvl) begin
         db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         db_lvl <= s2;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign lvl = db_lvl;
`else
   logic unused_cfg;
   assign unused_cfg = (DEBOUNCE_CYCLES > 0) && (CNT_W > 0);
   assign lvl        = s2;
`endif

   assign ld_evt   = lvl & ~p;
   assign digit_ok = (bus.D <= 4'd9);

   // State and operand registers
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= WAIT_X;
         x_q     <= 4'd0;
         y_q     <= 4'd0;
         ci_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         x_q     <= x_n;
         y_q     <= y_n;
         ci_q    <= ci_n;
         err_q   <= err_n;
      end
   end

   // Next-state and datapath. Without a load event everything holds. The one
   // exception is the unreachable encoding, which falls back to WAIT_X.
   always_comb begin
      state_n = state_q;
      x_n     = x_q;
      y_n     = y_q;
      ci_n    = ci_q;
      err_n   = err_q;
      case (state_q)
         WAIT_X: begin
            if (ld_evt) begin
               if (digit_ok) begin
                  x_n     = bus.D;
                  err_n   = 1'b0;
                  state_n = WAIT_Y;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         WAIT_Y: begin
            if (ld_evt) begin
               if (digit_ok) begin
                  y_n     = bus.D;
                  ci_n    = bus.Cin;
                  err_n   = 1'b0;
                  state_n = READY;
               end else begin
                  err_n = 1'b1;   // X is kept and ci is not sampled
               end
            end
         end
         READY: begin
            if (ld_evt) begin
               if (digit_ok) begin
                  // A new entry starts. Y and ci keep their old values until
                  // they are overwritten.
                  x_n     = bus.D;
                  err_n   = 1'b0;
                  state_n = WAIT_Y;
               end else begin
                  err_n = 1'b1;   // the previous operand set stays valid
               end
            end
         end
         default: begin
            state_n = WAIT_X;
         end
      endcase
   end

   // Valid is decoded from the state. It therefore changes on the same edge
   // as State, and it is low in the unreachable encoding.
   assign bus.X     = x_q;
   assign bus.Y     = y_q;
   assign bus.ci    = ci_q;
   assign bus.Valid = (state_q == READY);
   assign bus.Err   = err_q;
   assign bus.State = state_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
//------------------------------------------------------------------------------
// tb_bcd_operand_loader
//
// Directed bench for bcd_operand_loader. Each output snapshot is packed as
// {3'b0, X, Y, ci, Valid, Err, State}. It is compared against hand-computed
// values that go through an expected queue. Inputs are driven and outputs
// are sampled on the falling clock edge.
//------------------------------------------------------------------------------
module tb_bcd_operand_loader;

`ifdef BCD_OPERAND_LOADER_DEBOUNCE_EN
   localparam int LAT        = 19;
   localparam int PRESS_HOLD = 30;
   localparam int SETTLE     = 40;
`else
   localparam int LAT        = 3;
   localparam int PRESS_HOLD = 1;
   localparam int SETTLE     = 4;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic [15:0] exp_q[$];

   bcd_operand_loader_if bus ();

   bcd_operand_loader dut (
      .Clock  (clk),
      .Resetn (rst_n),
      .bus    (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   function automatic logic [15:0] mk(input logic [3:0] x, input logic [3:0] y,
                                      input logic c, input logic v,
                                      input logic e, input logic [1:0] s);
      return {3'b000, x, y, c, v, e, s};
   endfunction

   function automatic logic [15:0] snap();
      return {3'b000, bus.X, bus.Y, bus.ci, bus.Valid, bus.Err, bus.State};
   endfunction

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // scoreboard
   task automatic sb_expect(input string tag, input logic [15:0] exp);
      exp_q.push_back(exp);
      check(tag, snap(), exp_q.pop_front());
   endtask

   // drivers
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      bus.Load = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] d, input logic cin);
      @(negedge clk);
      bus.D    = d;
      bus.Cin  = cin;
      bus.Load = 1'b1;
      repeat (PRESS_HOLD) @(negedge clk);
      bus.Load = 1'b0;
      repeat (SETTLE) @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      bus.D    = 4'd5;
      bus.Cin  = 1'b0;
      bus.Load = 1'b1;

      // reset with Load held high, then capture exactly LAT edges after release
      repeat (2) @(negedge clk);
      sb_expect("reset_state", mk(0, 0, 0, 0, 0, 2'b00));
      rst_n = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      sb_expect("release_before_lat", mk(0, 0, 0, 0, 0, 2'b00));
      @(negedge clk);
      sb_expect("release_capture_x5", mk(5, 0, 0, 0, 0, 2'b01));
      bus.Load = 1'b0;

      // normal entry
      do_reset();
      press(4'd7, 1'b0);
      sb_expect("load_x7", mk(7, 0, 0, 0, 0, 2'b01));

      // Y=9 ci=1 with Load held long: exactly one event
      @(negedge clk);
      bus.D    = 4'd9;
      bus.Cin  = 1'b1;
      bus.Load = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      sb_expect("load_y9_ci1", mk(7, 9, 1, 1, 0, 2'b10));
      repeat (16) @(negedge clk);
      sb_expect("hold_no_change", mk(7, 9, 1, 1, 0, 2'b10));
      bus.Load = 1'b0;
      repeat (SETTLE) @(negedge clk);
      sb_expect("hold_release_no_change", mk(7, 9, 1, 1, 0, 2'b10));

      // READY rejects an illegal digit and keeps the operand set
      press(4'd15, 1'b0);
      sb_expect("ready_reject_15", mk(7, 9, 1, 1, 1, 2'b10));
      press(4'd10, 1'b0);
      sb_expect("ready_reject_10", mk(7, 9, 1, 1, 1, 2'b10));

      // re-entry from READY; Y and ci are kept
      press(4'd4, 1'b0);
      sb_expect("reentry_x4", mk(4, 9, 1, 0, 0, 2'b01));

      // reset mid-entry clears on the next edge
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      sb_expect("mid_entry_reset", mk(0, 0, 0, 0, 0, 2'b00));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // illegal digit in WAIT_X, then a legal one
      press(4'd12, 1'b0);
      sb_expect("wait_x_reject_12", mk(0, 0, 0, 0, 1, 2'b00));
      press(4'd3, 1'b0);
      sb_expect("wait_x_load_3", mk(3, 0, 0, 0, 0, 2'b01));

      // illegal digit in WAIT_Y: ci must not be sampled
      press(4'd11, 1'b1);
      sb_expect("wait_y_reject_11", mk(3, 0, 0, 0, 1, 2'b01));
      press(4'd0, 1'b1);
      sb_expect("wait_y_load_0", mk(3, 0, 1, 1, 0, 2'b10));

`ifdef BCD_OPERAND_LOADER_DEBOUNCE_EN
      do_reset();
      // 10-cycle glitch: filtered out
      @(negedge clk);
      bus.D    = 4'd6;
      bus.Load = 1'b1;
      repeat (10) @(negedge clk);
      bus.Load = 1'b0;
      repeat (SETTLE) @(negedge clk);
      sb_expect("glitch_ignored", mk(0, 0, 0, 0, 0, 2'b00));
      // 30-cycle press: capture on the 19th edge after the rise
      @(negedge clk);
      bus.Load = 1'b1;
      repeat (18) @(negedge clk);
      sb_expect("debounce_before_19", mk(0, 0, 0, 0, 0, 2'b00));
      @(negedge clk);
      sb_expect("debounce_at_19", mk(6, 0, 0, 0, 0, 2'b01));
      repeat (11) @(negedge clk);
      bus.Load = 1'b0;
      repeat (SETTLE) @(negedge clk);
      sb_expect("debounce_single_event", mk(6, 0, 0, 0, 0, 2'b01));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
